// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared types and helpers for the iterative RV32M multiply/divide unit.
//   mdu_op_e    : operation codes, identical to the RV32M funct3 encoding
//   mdu_state_e : controller states IDLE -> CALC -> DONE
//   is_div / is_rem / a_signed / b_signed : operation classification helpers
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_OP_LENGTH = 3;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    // Divide family (quotient or remainder).
    function automatic logic is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Remainder-producing operations.
    function automatic logic is_rem(input mdu_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // rs1 interpreted as two's complement. MUL is treated as unsigned since
    // the low half of the product does not depend on operand signedness.
    function automatic logic a_signed(input mdu_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 interpreted as two's complement (MULHSU keeps rs2 unsigned).
    function automatic logic b_signed(input mdu_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// -----------------------------------------------------------------------------
// mdu_negate
// Combinational conditional two's complement: out = neg ? -in : in.
// Used for operand magnitude extraction and final result sign fixup.
//   in  [W-1:0] : value
//   neg         : 1 = negate
//   out [W-1:0] : result (modulo 2^W)
// -----------------------------------------------------------------------------
module mdu_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] in,
    input  logic         neg,
    output logic [W-1:0] out
);

    assign out = neg ? (~in + {{(W-1){1'b0}}, 1'b1}) : in;

endmodule

// File: rtl/mdu_iterative.sv
// -----------------------------------------------------------------------------
// mdu_iterative
// Iterative RV32M multiply/divide unit with valid/ready handshake.
// Multiplies use a radix-2 unsigned shift-add on operand magnitudes, divides
// use restoring division; signs are re-applied in the final iteration.
// Divide-by-zero and signed overflow are resolved at accept time.
//   clk, reset (async, active-high), flush (sync abort)
//   in_valid / in_ready      : request handshake (in_ready only in IDLE)
//   Operation [OP_LENGTH-1:0]: funct3 code (see mdu_op_e)
//   SrcA, SrcB               : rs1, rs2
//   out_valid / out_ready    : result handshake, Result held until taken
//   Result [DATA_WIDTH-1:0]  : registered result
//   busy                     : unit not in IDLE
// -----------------------------------------------------------------------------
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_LENGTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_LENGTH-1:0]  Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  busy
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [W-1:0]     MIN_C      = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT_C = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT_C  = CNT_W'(1);

    // State
    mdu_state_e      state_r;
    mdu_op_e         op_r;
    logic            sa_r;
    logic            sb_r;
    logic [W-1:0]    op_a_r;      // |rs1|: multiplicand
    logic [W-1:0]    op_b_r;      // |rs2|: divisor
    logic [2*W-1:0]  acc_r;       // mul: {partial, multiplier}; div: low half = dividend/quotient
    logic [W-1:0]    rem_r;       // partial remainder
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]    result_r;
    logic            out_valid_r;

    // Request decode
    mdu_op_e         op_in_s;
    logic            neg_a_in_s;
    logic            neg_b_in_s;
    logic [W-1:0]    abs_a_s;
    logic [W-1:0]    abs_b_s;
    logic            accept_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic            special_s;
    logic [W-1:0]    special_result_s;

    // Iteration datapath
    logic [W:0]      mul_sum_s;
    logic [2*W-1:0]  mul_next_s;
    logic [W:0]      rem_shift_s;
    logic [W:0]      trial_s;
    logic            div_ge_s;
    logic [W-1:0]    rem_next_s;
    logic [W-1:0]    quo_next_s;
    logic [2*W-1:0]  acc_next_s;
    logic [2*W-1:0]  prod_fix_s;
    logic [W-1:0]    quo_fix_s;
    logic [W-1:0]    rem_fix_s;
    logic [W-1:0]    final_result_s;

    assign op_in_s    = mdu_op_e'(Operation);
    assign neg_a_in_s = a_signed(op_in_s) & SrcA[W-1];
    assign neg_b_in_s = b_signed(op_in_s) & SrcB[W-1];

    assign in_ready  = (state_r == IDLE) && !flush;
    assign accept_s  = in_valid && in_ready;
    assign busy      = (state_r != IDLE);
    assign out_valid = out_valid_r;
    assign Result    = result_r;

    mdu_negate #(.W(W)) u_abs_a (.in(SrcA), .neg(neg_a_in_s), .out(abs_a_s));
    mdu_negate #(.W(W)) u_abs_b (.in(SrcB), .neg(neg_b_in_s), .out(abs_b_s));

    assign div_zero_s = is_div(op_in_s) && (SrcB == {W{1'b0}});
    assign ovf_s      = ((op_in_s == OP_DIV) || (op_in_s == OP_REM)) &&
                        (SrcA == MIN_C) && (SrcB == {W{1'b1}});

    // Preset result for cases that bypass the iteration.
    always_comb begin
        special_s        = 1'b0;
        special_result_s = {W{1'b0}};
        if (div_zero_s) begin
            special_s        = 1'b1;
            special_result_s = is_rem(op_in_s) ? SrcA : {W{1'b1}};
        end else if (ovf_s) begin
            special_s        = 1'b1;
            special_result_s = is_rem(op_in_s) ? {W{1'b0}} : MIN_C;
        end else begin
            special_s        = 1'b0;
            special_result_s = {W{1'b0}};
        end
    end

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right including the carry.
    assign mul_sum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, op_a_r} : {(W+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_r[W-1:1]};

    // Restoring step. The shifted remainder is below 2*divisor, so the
    // borrow bit of the W+1-bit trial subtraction alone decides the quotient bit.
    assign rem_shift_s = {rem_r, acc_r[W-1]};
    assign trial_s     = rem_shift_s - {1'b0, op_b_r};
    assign div_ge_s    = ~trial_s[W];
    assign rem_next_s  = div_ge_s ? trial_s[W-1:0] : rem_shift_s[W-1:0];
    assign quo_next_s  = {acc_r[W-2:0], div_ge_s};
    assign acc_next_s  = is_div(op_r) ? {{W{1'b0}}, quo_next_s} : mul_next_s;

    mdu_negate #(.W(2*W)) u_fix_prod (.in(mul_next_s), .neg(sa_r ^ sb_r), .out(prod_fix_s));
    mdu_negate #(.W(W))   u_fix_quo  (.in(quo_next_s), .neg(sa_r ^ sb_r), .out(quo_fix_s));
    mdu_negate #(.W(W))   u_fix_rem  (.in(rem_next_s), .neg(sa_r),        .out(rem_fix_s));

    // Result selection for the last iteration.
    always_comb begin
        final_result_s = {W{1'b0}};
        case (op_r)
            OP_MUL:                          final_result_s = prod_fix_s[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:    final_result_s = prod_fix_s[2*W-1:W];
            OP_DIV, OP_DIVU:                 final_result_s = quo_fix_s;
            OP_REM, OP_REMU:                 final_result_s = rem_fix_s;
            default:                         final_result_s = {W{1'b0}};
        endcase
    end

    // Controller and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            op_r        <= OP_MUL;
            sa_r        <= 1'b0;
            sb_r        <= 1'b0;
            op_a_r      <= {W{1'b0}};
            op_b_r      <= {W{1'b0}};
            acc_r       <= {(2*W){1'b0}};
            rem_r       <= {W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            result_r    <= {W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (flush) begin
            // Result intentionally keeps its last value.
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r   <= op_in_s;
                        sa_r   <= neg_a_in_s;
                        sb_r   <= neg_b_in_s;
                        op_a_r <= abs_a_s;
                        op_b_r <= abs_b_s;
                        acc_r  <= {{W{1'b0}}, (is_div(op_in_s) ? abs_a_s : abs_b_s)};
                        rem_r  <= {W{1'b0}};
                        cnt_r  <= {CNT_W{1'b0}};
                        if (special_s) begin
                            result_r    <= special_result_s;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_r <= acc_next_s;
                    rem_r <= rem_next_s;
                    if (cnt_r == LAST_CNT_C) begin
                        cnt_r       <= {CNT_W{1'b0}};
                        result_r    <= final_result_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + ONE_CNT_C;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// -----------------------------------------------------------------------------
// tb_mdu_iterative
// Directed bench for mdu_iterative (DATA_WIDTH=32). A reference model computes
// RV32M results with plain integer arithmetic; a compare process checks Result
// and latency on every cycle out_valid is high.
// -----------------------------------------------------------------------------
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  Operation = 3'd0;
    logic [31:0] SrcA = 32'd0;
    logic [31:0] SrcB = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Result;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
        string       name;
    } exp_t;
    exp_t exp_q[$];
    bit   seen = 1'b0;

    mdu_iterative #(.DATA_WIDTH(32), .OP_LENGTH(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .Operation(Operation),
        .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .out_ready(out_ready), .Result(Result), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: RISC-V M-extension semantics from plain arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Compare process: every cycle out_valid is high, Result must match the
    // head of the expectation queue; latency is checked on the first such cycle.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_out_valid: got out_valid=1 expected 0 (Result %h)", Result);
            end else begin
                chk(exp_q[0].name, Result, exp_q[0].res);
                if (!seen) begin
                    seen = 1'b1;
                    chk({exp_q[0].name, "_latency"}, 32'(cyc - exp_q[0].acc_cyc + 1), 32'(exp_q[0].lat));
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Issue one request; the literal pins the model against a hand-computed value.
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit);
        exp_t e;
        int   t;
        chk({name, "_model"}, model(op, a, b), lit);
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk({name, "_in_ready_timeout"}, {31'd0, in_ready}, 32'd1);
            return;
        end
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.res     = model(op, a, b);
        e.lat     = model_lat(op, a, b);
        e.acc_cyc = cyc;
        e.name    = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_done_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            seen = 1'b0;
        end
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit);
        issue(name, op, a, b, lit);
        wait_done(name);
    endtask

    initial begin
        int t;
        int vcount;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_result",    Result,             32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

        // Multiplies
        run("mul_7_neg3",      3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run("mulhu_max_sq",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("mulh_min_sq",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run("mulhsu_m1_max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("mulh_neg3_5",     3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF);
        run("mulhu_min_2",     3'd3, 32'h8000_0000, 32'd2,         32'd1);
        run("mul_3_5",         3'd0, 32'd3,         32'd5,         32'd15);

        // Divides
        run("div_neg7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run("rem_neg7_2",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run("divu_100_7",      3'd5, 32'd100,       32'd7,         32'd14);
        run("remu_100_7",      3'd7, 32'd100,       32'd7,         32'd2);
        run("div_7_neg2",      3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run("rem_7_neg2",      3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1);
        run("divu_max_1",      3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF);

        // Special cases (1-cycle latency)
        run("div_x_by0",       3'd4, 32'd1234,      32'd0,         32'hFFFF_FFFF);
        run("divu_5_by0",      3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF);
        run("remu_5_by0",      3'd7, 32'd5,         32'd0,         32'd5);
        run("rem_neg7_by0",    3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
        run("div_ovf",         3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run("rem_ovf",         3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Backpressure: hold DONE, try to push a new request meanwhile
        out_ready = 1'b0;
        issue("bp_divu", 3'd5, 32'd100, 32'd7, 32'd14);
        in_valid  = 1'b1;
        Operation = 3'd0;
        SrcA      = 32'd9;
        SrcB      = 32'd9;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bp_reached_done", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid",    {31'd0, out_valid}, 32'd1);
            chk("bp_hold_in_ready", {31'd0, in_ready},  32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid",    {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready},  32'd1);
        chk("bp_release_queue",    32'(exp_q.size()),  32'd0);
        run("bp_next_mulhu", 3'd3, 32'h8000_0000, 32'd2, 32'd1);

        // Flush at CALC cycle 10 with a competing request
        issue("flush_mul", 3'd0, 32'd3, 32'd5, 32'd15);
        repeat (10) @(posedge clk);
        #1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        Operation = 3'd5;
        SrcA      = 32'd5;
        SrcB      = 32'd0;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        @(negedge clk);
        chk("flush_busy",      {31'd0, busy},      32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("flush_no_valid", 32'(vcount), 32'd0);
        chk("flush_result_kept", Result, 32'd1);

        // Asynchronous reset mid-CALC
        issue("rst_divu", 3'd5, 32'd100, 32'd7, 32'd14);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy",      {31'd0, busy},      32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_result",    Result,             32'd0);
        exp_q.delete();
        seen = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        run("after_rst_rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run("after_rst_divu", 3'd5, 32'd100,       32'd7, 32'd14);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
